linreg_mac_engine: RTL and testbench

Parametrised, sequential successor of the combinational three-feature linear-regression datapath. Computes y = INTERCEPT + sum(SLOPE[i]*X[i]) for N_FEAT signed fixed-point features. It uses one shared signed multiplier-accumulator, one feature per clock, with runtime-loadable coefficients and valid/ready handshakes on input and output. It sits between the feature-vector source and the price/result consumer, and adds saturation and an overflow flag.

---
 rtl/linreg_mac_engine.sv | 172 +++++++++++++++++
 tb/tb_linreg_mac_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/linreg_mac_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : linreg_mac_engine
// Purpose  : Sequential linear regression, y = INTERCEPT + sum(SLOPE[i]*X[i]),
//            using one shared signed MAC, with an output saturation stage.
// Revision : 1.0  initial release
// ============================================================================
module linreg_mac_engine #(
    parameter int N_FEAT = 3,
    parameter int DATA_W = 16,
    parameter int COEF_W = 24,
    parameter int FRAC_W = 0,
    parameter int ACC_W  = 48,
    parameter int OUT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     coef_we,
    input  logic [3:0]               coef_addr,
    input  logic [COEF_W-1:0]        coef_wdata,
    output logic                     coef_err,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_FEAT*DATA_W-1:0] in_x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_y,
    output logic                     out_ovf
);

    localparam int IDX_W  = 4;
    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic signed [ACC_W-1:0] c_OUT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_OUT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // FIN is the registered saturation stage between the last MAC and DONE
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                     r_state;
    logic [IDX_W-1:0]           r_idx;
    logic [N_FEAT*DATA_W-1:0]   r_x;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [COEF_W-1:0]   r_icpt;
    logic signed [COEF_W-1:0]   r_slope [N_FEAT];
    logic                       r_in_ready;
    logic                       r_out_valid;
    logic [OUT_W-1:0]           r_out_y;
    logic                       r_out_ovf;
    logic                       r_coef_err;

    logic signed [DATA_W-1:0]   w_x_sel;
    logic signed [COEF_W-1:0]   w_slope_sel;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic signed [ACC_W-1:0]    w_icpt_ext;
    logic signed [ACC_W-1:0]    w_res;
    logic                       w_hs;
    logic                       w_addr_ok;
    logic                       w_coef_ok;

    always_comb begin
        w_x_sel     = '0;
        w_slope_sel = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_x_sel     = r_x[i*DATA_W +: DATA_W];
                w_slope_sel = r_slope[i];
            end
        end
    end

    assign w_prod     = PROD_W'(w_x_sel) * PROD_W'(w_slope_sel);
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_acc_next = r_acc + w_prod_ext;
    assign w_icpt_ext = {{(ACC_W-COEF_W){r_icpt[COEF_W-1]}}, r_icpt} <<< FRAC_W;
    assign w_res      = r_acc >>> FRAC_W;

    assign w_hs       = in_valid && r_in_ready;
    assign w_addr_ok  = (coef_addr <= IDX_W'(N_FEAT));
    assign w_coef_ok  = coef_we && (r_state == S_IDLE) && !w_hs && w_addr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_x         <= '0;
            r_acc       <= '0;
            r_icpt      <= '0;
            for (int i = 0; i < N_FEAT; i++) begin
                r_slope[i] <= '0;
            end
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_ovf   <= 1'b0;
            r_coef_err  <= 1'b0;
        end else begin
            r_coef_err <= coef_we && !w_coef_ok;
            if (w_coef_ok) begin
                if (coef_addr == 4'd0) begin
                    r_icpt <= coef_wdata;
                end
                for (int i = 0; i < N_FEAT; i++) begin
                    if (coef_addr == IDX_W'(i + 1)) begin
                        r_slope[i] <= coef_wdata;
                    end
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_x        <= in_x;
                        r_acc      <= w_icpt_ext;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(N_FEAT - 1)) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    if (w_res > c_OUT_MAX) begin
                        r_out_y   <= c_OUT_MAX[OUT_W-1:0];
                        r_out_ovf <= 1'b1;
                    end else if (w_res < c_OUT_MIN) begin
                        r_out_y   <= c_OUT_MIN[OUT_W-1:0];
                        r_out_ovf <= 1'b1;
                    end else begin
                        r_out_y   <= w_res[OUT_W-1:0];
                        r_out_ovf <= 1'b0;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign coef_err  = r_coef_err;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_linreg_mac_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_linreg_mac_engine
// Purpose  : Self-checking bench for linreg_mac_engine against a plain
//            integer model of the regression with output saturation.
// Revision : 1.0  initial release
// ============================================================================
module tb_linreg_mac_engine;

    localparam int N_FEAT = 3;
    localparam int DATA_W = 16;
    localparam int COEF_W = 24;
    localparam int OUT_W  = 32;

    logic                     clk;
    logic                     rst_n;
    logic                     coef_we;
    logic [3:0]               coef_addr;
    logic [COEF_W-1:0]        coef_wdata;
    logic                     coef_err;
    logic                     in_valid;
    logic                     in_ready;
    logic [N_FEAT*DATA_W-1:0] in_x;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_y;
    logic                     out_ovf;

    linreg_mac_engine #(
        .N_FEAT (N_FEAT),
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .FRAC_W (0),
        .ACC_W  (48),
        .OUT_W  (OUT_W)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_err   (coef_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_ovf    (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     n_cmp  = 0;
    int     n_fail = 0;
    int     hs_cyc = 0;
    longint m_icpt;
    longint m_slope [N_FEAT];
    longint m_x     [N_FEAT];
    longint exp_y;
    longint exp_ovf;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic longint rand_s(input int w);
        longint v;
        v = longint'({$urandom, $urandom}) & ((64'sd1 <<< w) - 1);
        if (v >= (64'sd1 <<< (w - 1))) v = v - (64'sd1 <<< w);
        return v;
    endfunction

    // Reference: exact integer sum, then clamp to the signed output range
    task automatic calc();
        longint s;
        s = m_icpt;
        for (int i = 0; i < N_FEAT; i++) s = s + m_slope[i] * m_x[i];
        if (s > 64'sd2147483647) begin
            exp_y = 64'sd2147483647; exp_ovf = 1;
        end else if (s < -64'sd2147483648) begin
            exp_y = -64'sd2147483648; exp_ovf = 1;
        end else begin
            exp_y = s; exp_ovf = 0;
        end
    endtask

    task automatic write_coef(input int addr, input longint val, input bit exp_err);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = 4'(addr);
        coef_wdata = COEF_W'(val);
        @(posedge clk); #1;
        check("coef_err_write", coef_err, exp_err);
        coef_we = 1'b0;
        if (!exp_err) begin
            if (addr == 0) m_icpt = val;
            else m_slope[addr-1] = val;
        end
        @(posedge clk); #1;
        check("coef_err_clear", coef_err, 0);
    endtask

    task automatic load_all(input longint ic, input longint s0, input longint s1,
                            input longint s2);
        write_coef(0, ic, 0);
        write_coef(1, s0, 0);
        write_coef(2, s1, 0);
        write_coef(3, s2, 0);
    endtask

    task automatic hs(input longint x0, input longint x1, input longint x2);
        m_x[0] = x0; m_x[1] = x1; m_x[2] = x2;
        calc();
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = {DATA_W'(x2), DATA_W'(x1), DATA_W'(x0)};
        check("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        hs_cyc   = cyc;
        in_valid = 1'b0;
        in_x     = {$urandom, $urandom};
        check("in_ready_busy", in_ready, 0);
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_valid_seen", out_valid, 1);
        check("latency", cyc - hs_cyc, N_FEAT + 1);
        check("out_y", $signed(out_y), exp_y);
        check("out_ovf", out_ovf, exp_ovf);
    endtask

    task automatic accept();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    task automatic run_vec(input longint x0, input longint x1, input longint x2);
        hs(x0, x1, x2);
        wait_result();
        accept();
    endtask

    initial begin
        rst_n = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
        m_icpt = 0;
        for (int i = 0; i < N_FEAT; i++) m_slope[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_y", out_y, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_coef_err", coef_err, 0);

        load_all(-8153, 717, 36824, 101572);
        run_vec(2, 1, 1);
        check("tp1_value", exp_y, 131677);

        load_all(100, -3, 5, 0);
        run_vec(-10, -4, 7);
        run_vec(0, 0, 0);

        load_all(0, 8388607, 8388607, 8388607);
        run_vec(32767, 32767, 32767);
        run_vec(-32768, -32768, -32768);

        // Back-pressure with in_valid/in_x toggling while the result waits
        load_all(-5000, 1234, -77, 9);
        hs(300, -200, 12345);
        wait_result();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            in_x     = {$urandom, $urandom};
            @(posedge clk); #1;
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
            check("hold_out_y", $signed(out_y), exp_y);
        end
        in_valid = 1'b0;
        accept();
        run_vec(-1, 2, -3);

        // Write during MAC is rejected and does not alter the result
        hs(11, 22, 33);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 4'd1; coef_wdata = 24'd999;
        @(posedge clk); #1;
        check("mac_write_err", coef_err, 1);
        coef_we = 1'b0;
        @(posedge clk); #1;
        check("mac_write_clear", coef_err, 0);
        wait_result();
        accept();
        run_vec(11, 22, 33);

        write_coef(5, 4242, 1);
        write_coef(4, 4242, 1);
        run_vec(11, 22, 33);

        // Reset two cycles into MAC
        hs(7, 8, 9);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_in_ready", in_ready, 1);
        m_icpt = 0;
        for (int i = 0; i < N_FEAT; i++) m_slope[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(rand_s(DATA_W), rand_s(DATA_W), rand_s(DATA_W));
        check("rst_zero_result", exp_y, 0);

        for (int t = 0; t < 16; t++) begin
            if (t % 4 == 0) begin
                int w;
                w = (t == 0) ? 8 : (t == 4) ? 12 : COEF_W;
                load_all(rand_s(COEF_W), rand_s(w), rand_s(w), rand_s(w));
            end
            run_vec(rand_s(DATA_W), rand_s(DATA_W), rand_s(DATA_W));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
